// File: rtl/accum_scoreboard.sv
// Self-timed checker for the secret-constant accumulator: runs a cycle-accurate
// reference model alongside the DUT and reports pass/fail with the first failing index.
module accum_scoreboard #(
  parameter int                WIDTH      = 32,
  parameter int                SECRET     = 7,
  parameter logic [WIDTH-1:0]  INIT_VALUE = '0,
  parameter int                NUM_CHECKS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] accum_in,
  input  logic             accum_bypass,
  input  logic [WIDTH-1:0] accum_out,
  input  logic [WIDTH-1:0] accum_bypass_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [15:0]      first_err_idx,
  output logic [WIDTH-1:0] expect_out
);

  localparam logic [WIDTH-1:0] SECRET_W = WIDTH'(SECRET);
  localparam logic [15:0]      LAST_IDX = 16'(NUM_CHECKS - 1);
  localparam logic [15:0]      NO_ERR   = 16'hFFFF;

  typedef enum logic [1:0] {IDLE, PRIME, CHECK, DONE} state_t;

  state_t      state;
  logic [15:0] check_idx;

  logic [WIDTH-1:0] byp_ref;
  logic             acc_ok;
  logic             byp_ok;
  logic             mismatch;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [WIDTH-1:0] model_next(input logic [WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0] din);
    return acc + din + SECRET_W;
  endfunction

  // Compare against the pre-update model value. The mismatch flag defaults high and
  // is cleared only on a definite match, so unknown DUT values count as errors.
  always_comb begin
    byp_ref  = accum_bypass ? accum_in : expect_out;
    acc_ok   = (accum_out == expect_out);
    byp_ok   = (accum_bypass_out == byp_ref);
    mismatch = 1'b1;
    if (acc_ok && byp_ok) mismatch = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_idx <= NO_ERR;
      expect_out    <= INIT_VALUE;
      check_idx     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= PRIME;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= NO_ERR;
            expect_out    <= INIT_VALUE;
            check_idx     <= '0;
          end
        end
        PRIME: begin
          // DUT still shows INIT_VALUE this cycle, so only advance the model
          expect_out <= model_next(expect_out, accum_in);
          state      <= CHECK;
        end
        CHECK: begin
          expect_out <= model_next(expect_out, accum_in);
          check_idx  <= check_idx + 16'd1;
          if (mismatch) begin
            err_count <= sat_inc(err_count);
            if (first_err_idx == NO_ERR) first_err_idx <= check_idx;
          end
          if (check_idx == LAST_IDX) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == 16'd0) && !mismatch;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_scoreboard.sv
// Scoreboard bench for accum_scoreboard: a behavioural golden accumulator feeds the
// checker, expected run results are queued at stimulus time and popped on done.
module tb_accum_scoreboard;

  typedef struct packed {
    logic        pass;
    logic [15:0] err;
    logic [15:0] fei;
    logic [31:0] exp_acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // instance A: INIT_VALUE = 0
  logic        start = 1'b0;
  logic [31:0] accum_in = '0;
  logic        accum_bypass = 1'b0;
  logic [31:0] accum_out, accum_bypass_out;
  logic        busy, done, pass;
  logic [15:0] err_count, first_err_idx;
  logic [31:0] expect_out;

  // instance B: INIT_VALUE = 32'hFFFF_FFF8 for wrap-around
  logic        start_b = 1'b0;
  logic [31:0] accum_in_b = '0;
  logic [31:0] accum_out_b;
  logic        busy_b, done_b, pass_b;
  logic [15:0] err_count_b, first_err_idx_b;
  logic [31:0] expect_out_b;

  // golden DUT models and fault injection
  logic [31:0] dut_acc;
  logic [31:0] dut_acc_b;
  logic        dut_rst = 1'b1;
  logic        dut_rst_b = 1'b1;
  logic        corrupt = 1'b0;
  logic        byp_bad = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  bit   done_q_a = 1'b0;
  bit   done_q_b = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    dut_acc   <= dut_rst   ? 32'd0          : dut_acc + accum_in + 32'd7;
    dut_acc_b <= dut_rst_b ? 32'hFFFF_FFF8  : dut_acc_b + accum_in_b + 32'd7;
  end

  assign accum_out        = dut_acc ^ {31'd0, corrupt};
  assign accum_bypass_out = byp_bad ? accum_out : (accum_bypass ? accum_in : accum_out);
  assign accum_out_b      = dut_acc_b;

  accum_scoreboard #(.WIDTH(32), .SECRET(7), .INIT_VALUE(32'd0), .NUM_CHECKS(10)) u_dut_a (
    .clk(clk), .rst(rst), .start(start),
    .accum_in(accum_in), .accum_bypass(accum_bypass),
    .accum_out(accum_out), .accum_bypass_out(accum_bypass_out),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_idx(first_err_idx), .expect_out(expect_out)
  );

  accum_scoreboard #(.WIDTH(32), .SECRET(7), .INIT_VALUE(32'hFFFF_FFF8), .NUM_CHECKS(10)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .accum_in(accum_in_b), .accum_bypass(1'b0),
    .accum_out(accum_out_b), .accum_bypass_out(accum_out_b),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_count_b), .first_err_idx(first_err_idx_b), .expect_out(expect_out_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // monitors: pop one expected result per rising done
  always @(negedge clk) begin
    if (done && !done_q_a) begin
      if (qa.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL a_unexpected_done: got done=1, expected no run result (t=%0t)", $time);
      end else begin
        ea = qa.pop_front();
        chk("a_pass", {31'd0, pass}, {31'd0, ea.pass});
        chk("a_err_count", {16'd0, err_count}, {16'd0, ea.err});
        chk("a_first_err_idx", {16'd0, first_err_idx}, {16'd0, ea.fei});
        chk("a_expect_out", expect_out, ea.exp_acc);
      end
    end
    done_q_a = done;
  end

  always @(negedge clk) begin
    if (done_b && !done_q_b) begin
      if (qb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL b_unexpected_done: got done=1, expected no run result (t=%0t)", $time);
      end else begin
        eb = qb.pop_front();
        chk("b_pass", {31'd0, pass_b}, {31'd0, eb.pass});
        chk("b_err_count", {16'd0, err_count_b}, {16'd0, eb.err});
        chk("b_first_err_idx", {16'd0, first_err_idx_b}, {16'd0, eb.fei});
        chk("b_expect_out", expect_out_b, eb.exp_acc);
      end
    end
    done_q_b = done_b;
  end

  // One run on instance A with accum_in = 0,5,10,...; index arguments of -1/99 disable a feature.
  task automatic run_a(input int corrupt_idx, input int byp_from, input bit bad_byp,
                       input int abort_idx, input int glitch_idx, input bit trace);
    logic [31:0] trace_tab [2];
    trace_tab[0] = 32'd19;
    trace_tab[1] = 32'd36;
    start = 1'b1; dut_rst = 1'b1; accum_in = '0; accum_bypass = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; dut_rst = 1'b0;
    chk("busy_in_prime", {31'd0, busy}, 32'd1);
    accum_in = 32'd0;
    @(posedge clk); #1;
    if (trace) chk("expect_after_prime", expect_out, 32'd7);
    for (int i = 0; i < 10; i++) begin
      accum_in     = 32'(5 * (i + 1));
      accum_bypass = (i >= byp_from);
      corrupt      = (i == corrupt_idx);
      byp_bad      = bad_byp;
      start        = (i == glitch_idx);
      if (i == abort_idx) begin
        chk("err_before_abort", {16'd0, err_count}, (corrupt_idx >= 0 && corrupt_idx < i) ? 32'd1 : 32'd0);
        rst = 1'b1;
      end
      if (i == 9) chk("busy_before_last", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      start = 1'b0; corrupt = 1'b0;
      if (trace && i < 2) chk("expect_trace", expect_out, trace_tab[i]);
      if (i == abort_idx) begin
        rst = 1'b0; accum_bypass = 1'b0; byp_bad = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_err_count", {16'd0, err_count}, 32'd0);
        chk("abort_first_err_idx", {16'd0, first_err_idx}, 32'h0000_FFFF);
        chk("abort_expect_out", expect_out, 32'd0);
        return;
      end
    end
    accum_bypass = 1'b0; byp_bad = 1'b0;
    chk("done_at_n_plus_11", {31'd0, done}, 32'd1);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected completion within budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_err_count", {16'd0, err_count}, 32'd0);
    chk("rst_first_err_idx", {16'd0, first_err_idx}, 32'h0000_FFFF);
    chk("rst_expect_out", expect_out, 32'd0);
    chk("rst_expect_out_b", expect_out_b, 32'hFFFF_FFF8);
    rst = 1'b0;
    @(posedge clk); #1;

    // wrap-around on instance B with accum_in = 0
    qb.push_back('{pass: 1'b1, err: 16'd0, fei: 16'hFFFF, exp_acc: 32'h0000_0045});
    start_b = 1'b1; dut_rst_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0; dut_rst_b = 1'b0;
    @(posedge clk); #1;
    chk("wrap_after_prime", expect_out_b, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    chk("wrap_after_first_check", expect_out_b, 32'h0000_0006);
    repeat (9) @(posedge clk);
    #1;
    chk("wrap_done", {31'd0, done_b}, 32'd1);

    // golden run: 11 model updates, sum(0..50 step 5)=275 plus 77
    qa.push_back('{pass: 1'b1, err: 16'd0, fei: 16'hFFFF, exp_acc: 32'd352});
    run_a(-1, 99, 1'b0, -1, -1, 1'b1);
    qa.push_back('{pass: 1'b0, err: 16'd1, fei: 16'd3, exp_acc: 32'd352});
    run_a(3, 99, 1'b0, -1, -1, 1'b0);
    qa.push_back('{pass: 1'b1, err: 16'd0, fei: 16'hFFFF, exp_acc: 32'd352});
    run_a(-1, 5, 1'b0, -1, -1, 1'b0);
    qa.push_back('{pass: 1'b0, err: 16'd5, fei: 16'd5, exp_acc: 32'd352});
    run_a(-1, 5, 1'b1, -1, -1, 1'b0);
    // aborted run with an early error; produces no result
    run_a(1, 99, 1'b0, 4, -1, 1'b0);
    // restart from IDLE with a start pulse mid-CHECK, then again from DONE
    qa.push_back('{pass: 1'b1, err: 16'd0, fei: 16'hFFFF, exp_acc: 32'd352});
    run_a(-1, 99, 1'b0, -1, 2, 1'b0);
    qa.push_back('{pass: 1'b1, err: 16'd0, fei: 16'hFFFF, exp_acc: 32'd352});
    run_a(-1, 99, 1'b0, -1, -1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("done_held", {31'd0, done}, 32'd1);
    chk("pass_held", {31'd0, pass}, 32'd1);
    chk("expect_frozen", expect_out, 32'd352);
    chk("qa_drained", 32'(qa.size()), 32'd0);
    chk("qb_drained", 32'(qb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
